// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of the single UART TX byte stream.
// Grants one requester at a time and snapshots its fixed-length frame.
// It streams the frame MSB-byte first under valid/ready, then holds an idle gap.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high
//   req       in   [N_REQ]        level requests
//   frame_in  in   [N_REQ*FB*DB]  requester i owns slice i
//   grant     out  [N_REQ]        one-hot owner of the current frame, or zero
//   done      out  one-cycle pulse after the last byte is accepted
//   busy      out  high whenever the arbiter is not idle
//   tx_data   out  [DBITS]        byte to the UART
//   tx_valid  out  tx_data is valid
//   tx_ready  in   UART accepts tx_data this cycle
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int FRAME_BYTES = 18,
    parameter int DBITS       = 8,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_REQ-1:0]                   req,
    input  logic [N_REQ*FRAME_BYTES*DBITS-1:0] frame_in,
    output logic [N_REQ-1:0]                   grant,
    output logic                               done,
    output logic                               busy,
    output logic [DBITS-1:0]                   tx_data,
    output logic                               tx_valid,
    input  logic                               tx_ready
);

    localparam int FW = FRAME_BYTES * DBITS;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW = PW + 1;
    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [FW-1:0]    r_buf;
    logic [CW-1:0]    r_cnt;
    logic [GW-1:0]    r_gcnt;
    logic [N_REQ-1:0] r_grant;
    logic             r_done;
    logic             r_valid;
    logic             r_busy;

    logic [SW-1:0]    w_sum;
    logic [PW-1:0]    w_idx;
    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_ptr_nxt;
    logic [N_REQ-1:0] w_onehot;
    logic [FW-1:0]    w_slice;
    logic             w_xfer;
    logic             w_last;

    // Search upward from the pointer; the sum is one bit wider than the
    // pointer so the wrap works for any N_REQ, power of two or not.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = SW'(r_ptr) + SW'(k);
            if (w_sum >= SW'(N_REQ)) begin
                w_sum = w_sum - SW'(N_REQ);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_slice = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win == PW'(k)) begin
                w_slice = frame_in[k*FW +: FW];
            end
        end
    end

    assign w_ptr_nxt = (w_win == PW'(N_REQ - 1)) ? '0 : w_win + PW'(1);
    assign w_onehot  = N_REQ'(1) << w_win;
    assign w_xfer    = r_valid && tx_ready;
    assign w_last    = (r_cnt == CW'(FRAME_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_grant <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_found) begin
                        r_grant <= w_onehot;
                        r_buf   <= w_slice;
                        r_cnt   <= '0;
                        r_ptr   <= w_ptr_nxt;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_SEND;
                    end else begin
                        r_grant <= '0;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        // Zeros shift in, so tx_data reads 0 once drained.
                        r_buf <= r_buf << DBITS;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            // Grant stays with the owner for the done cycle.
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_gcnt  <= '0;
                            if (GAP_CYCLES == 0) begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    // The first GAP cycle is the done cycle; the gap
                    // proper is the GAP_CYCLES cycles after it.
                    r_done  <= 1'b0;
                    r_grant <= '0;
                    if (r_gcnt == GW'(GAP_CYCLES)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign busy     = r_busy;
    assign tx_valid = r_valid;
    assign tx_data  = r_buf[FW-1 -: DBITS];

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the badge's single UART transmitter between several frame sources, e.g. challenge flag senders and status reporters. Each requester presents a fixed-length byte frame and raises a request. The arbiter grants one requester at a time, snapshots its frame, and streams it byte by byte into the UART TX byte interface under valid/ready handshake. It sits between the challenge logic and the `uart_top` transmit path, and enforces a programmable idle gap between frames.

## Interface
- `N_REQ`, default 4: number of requesters, allowed range 2..8.
- `FRAME_BYTES`, default 18: bytes per frame, allowed range 1..32.
- `DBITS`, default 8: bits per byte.
- `GAP_CYCLES`, default 16: idle cycles inserted after each frame; 0 means no gap.

Ports:
- `clk`, in, 1: single system clock. Everything is synchronous to its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, N_REQ: level request, one bit per requester.
- `frame_in`, in, N_REQ*FRAME_BYTES*DBITS: requester i occupies slice [(i+1)*FRAME_BYTES*DBITS-1 : i*FRAME_BYTES*DBITS]. Within a slice, the most significant byte is sent first.
- `grant`, out, N_REQ: one-hot, or all zero; identifies the owner of the current frame.
- `done`, out, 1: one-cycle pulse when the owner's last byte has been accepted.
- `busy`, out, 1: high in every state except IDLE.
- `tx_data`, out, DBITS: byte to the UART transmitter.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: the UART accepts `tx_data` this cycle.

## Operation
- States: IDLE, SEND, GAP. On reset the FSM enters IDLE.
- Round-robin pointer `ptr`, range 0..N_REQ-1, reset to 0.
- IDLE:
  - If `req` is non-zero, pick the first set bit searching upward from `ptr`, wrapping modulo N_REQ. Call it w.
  - Register `grant` = one-hot(w). Copy w's slice of `frame_in` into an internal shift buffer. Clear the byte counter. Set `ptr` to (w+1) mod N_REQ. Go to SEND.
- SEND:
  - `tx_valid` is high and `tx_data` is the current top byte of the buffer.
  - On each cycle where `tx_valid && tx_ready`: shift the buffer by DBITS and increment the counter.
  - When byte FRAME_BYTES-1 transfers: clear `tx_valid`, pulse `done`, and go to GAP (or to IDLE if GAP_CYCLES = 0).
- GAP:
  - `grant` is zero and `tx_valid` is low.
  - Count GAP_CYCLES cycles, then go to IDLE.
- Snapshot rule: changes on `frame_in`, or a drop of the owner's `req` after grant, do not affect the frame in flight. The frame always completes.
- A requester that holds `req` through `done` is re-arbitrated. Because `ptr` has already advanced, every other pending requester is served first.
- Requests arriving during SEND or GAP wait. Nothing is queued beyond the level of `req`.
- Width rules:
  - The byte counter is $clog2(FRAME_BYTES+1) bits wide.
  - The gap counter is $clog2(GAP_CYCLES+1) bits wide, minimum 1.
  - The pointer wraps modulo N_REQ, including when N_REQ is not a power of two.

## Timing
- Reset values:
  - `grant` = 0, `done` = 0, `busy` = 0, `tx_valid` = 0, `tx_data` = 0.
  - `ptr` = 0, counters = 0.
  - These hold asynchronously while `reset` is high.
- Request to first byte: `req` sampled high in IDLE at edge t gives `grant`, `busy`, `tx_valid` and the first `tx_data` all high/valid after edge t, i.e. 1 cycle of latency.
- Handshake:
  - `tx_data` is stable and `tx_valid` stays high until `tx_ready` is seen. `tx_valid` never drops mid-frame.
  - The next byte appears in the cycle after an accepted transfer.
  - With `tx_ready` held high, one byte transfers per cycle.
- Frame end:
  - In the cycle after the last transfer: `done` = 1, `grant` is still the owner, `tx_valid` = 0.
  - The following cycle: `grant` = 0.
- Minimum length of a frame slot: FRAME_BYTES + 1 + GAP_CYCLES cycles, plus 1 cycle of IDLE arbitration.
- Reset asserted mid-frame: the frame is abandoned and outputs clear immediately. After release, the FSM is in IDLE with `ptr` = 0 and no partial frame is resumed.
- Arbitration of simultaneous requests: decided solely by `ptr`, so no requester can win twice while another is pending.

## Test plan
- Single requester: `req` = 4'b0001, frame "{hi_i'm_your_army}", `tx_ready` held 1. Required: 18 bytes leave in order, 0x7b first and 0x7d last, on consecutive cycles; `done` pulses once; `grant` = 0001 throughout; 16 gap cycles follow.
- Backpressure: same frame, `tx_ready` toggling 1,0,0,1. Required: no byte lost or duplicated; `tx_data` stable during stalls; `done` only after byte 18 is accepted.
- Round-robin: `req` = 4'b1111 held continuously. Required: grant sequence 0001, 0010, 0100, 1000, 0001.
- Non-power-of-two pointer wrap: N_REQ = 3, `req` = 3'b101. Required: grant sequence 001, 100, 001.
- Snapshot: change the owner's `frame_in` and drop its `req` in the middle of SEND. Required: the original bytes complete unchanged.
- Reset mid-frame: assert `reset` at byte 5. Required: all outputs are 0 in the same cycle. After release with `req` = 4'b0010: grant 0010 and the first byte resent from the start.
